pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the single-cycle core. It owns the architectural PC register and resolves the next PC each cycle from decoded control-flow flags: sequential, bne/blt, j/jal, jr, bex, and an external redirect. It adds a return-address stack (RAS) so `ret` resolves without a register read, plus a stall hold. It sits between the decode/ALU-compare logic and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/ras_stack.sv | 60 ++++++
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared widths, reset PC and next-PC source encoding for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned PC_W_DEF      = 32;
  localparam int unsigned IMM_W_DEF     = 17;
  localparam int unsigned TGT_W_DEF     = 27;
  localparam int unsigned RAS_DEPTH_DEF = 4;
  localparam int unsigned RESET_PC_DEF  = 0;

  // Next-PC source selected by the priority mux.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_RET,
    SRC_JR,
    SRC_BEX,
    SRC_REDIR
  } pc_src_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with a saturating entry count; a push onto a full
// stack overwrites the oldest entry, a pop from an empty stack only flags underflow.
module ras_stack #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              push_data,
  output logic [W-1:0]              top,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] push_ptr;
  logic             full;
  logic             empty;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ptr = top_ptr + PTR_W'(1);
  assign top      = mem[top_ptr];

  // Entry storage carries no reset; contents are only read while count is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[push_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      top_ptr   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && full;
      underflow <= pop && !push && empty;
      if (push) begin
        top_ptr <= push_ptr;
        if (!full) begin
          count <= count + CNT_W'(1);
        end
      end else if (pop && !empty) begin
        top_ptr <= top_ptr - PTR_W'(1);
        count   <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register and next-PC priority mux for the single-cycle core,
// with a return-address stack so ret resolves without a register read.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W      = PC_W_DEF,
  parameter int unsigned     IMM_W     = IMM_W_DEF,
  parameter int unsigned     TGT_W     = TGT_W_DEF,
  parameter int unsigned     RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [PC_W-1:0]             redirect_pc,
  input  logic                        bne,
  input  logic                        blt,
  input  logic                        jp,
  input  logic                        jal,
  input  logic                        jr,
  input  logic                        ret,
  input  logic                        bex,
  input  logic                        is_not_equal,
  input  logic                        is_less_than,
  input  logic [PC_W-1:0]             reg_a,
  input  logic [PC_W-1:0]             reg_b,
  input  logic [IMM_W-1:0]            imm,
  input  logic [TGT_W-1:0]            target,
  output logic [PC_W-1:0]             pc,
  output logic [PC_W-1:0]             pc_plus1,
  output logic                        taken,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  pc_src_t         src;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] ret_target;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] pc_d;
  logic            br_taken;
  logic            ras_empty;
  logic            ras_push;
  logic            ras_pop;

  assign pc_plus1   = pc + PC_W'(1);
  assign br_target  = pc_plus1 + {{(PC_W - IMM_W){imm[IMM_W-1]}}, imm};
  assign jmp_target = PC_W'(target);
  assign ras_empty  = (ras_count == '0);
  assign ret_target = ras_empty ? reg_b : ras_top;
  assign br_taken   = (bne && is_not_equal) || (blt && is_less_than);

  // Source priority; jal outranks ret so a combined jal+ret only pushes.
  always_comb begin
    src = SRC_SEQ;
    if (redirect_valid) begin
      src = SRC_REDIR;
    end else if (bex && (reg_a != '0)) begin
      src = SRC_BEX;
    end else if (jr) begin
      src = SRC_JR;
    end else if (ret && !jal) begin
      src = SRC_RET;
    end else if (jp || jal) begin
      src = SRC_JMP;
    end else if (br_taken) begin
      src = SRC_BR;
    end
  end

  always_comb begin
    next_pc = pc_plus1;
    unique case (src)
      SRC_REDIR: next_pc = redirect_pc;
      SRC_BEX:   next_pc = jmp_target;
      SRC_JR:    next_pc = reg_b;
      SRC_RET:   next_pc = ret_target;
      SRC_JMP:   next_pc = jmp_target;
      SRC_BR:    next_pc = br_target;
      default:   next_pc = pc_plus1;
    endcase
  end

  // A redirect still lands while stalled; the RAS never moves under stall.
  always_comb begin
    pc_d     = next_pc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (stall && !redirect_valid) begin
      pc_d = pc;
    end
    if (!stall) begin
      ras_push = (src == SRC_JMP) && jal;
      ras_pop  = (src == SRC_RET);
    end
  end

  assign taken = (pc_d != pc_plus1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_d;
    end
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (PC_W=32, RAS depth 4, RESET_PC=0x40).
module tb_pc_sequencer;

  localparam logic [10:0] F_STALL = 11'h400;
  localparam logic [10:0] F_REDIR = 11'h200;
  localparam logic [10:0] F_BNE   = 11'h100;
  localparam logic [10:0] F_BLT   = 11'h080;
  localparam logic [10:0] F_JP    = 11'h040;
  localparam logic [10:0] F_JAL   = 11'h020;
  localparam logic [10:0] F_JR    = 11'h010;
  localparam logic [10:0] F_RET   = 11'h008;
  localparam logic [10:0] F_BEX   = 11'h004;
  localparam logic [10:0] F_INE   = 11'h002;
  localparam logic [10:0] F_ILT   = 11'h001;

  typedef struct {
    string       name;
    logic [10:0] flags;
    logic [31:0] rpc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [16:0] imm;
    logic [26:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_taken;
    logic [2:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, redirect_valid, bne, blt, jp, jal, jr, ret, bex;
  logic        is_not_equal, is_less_than;
  logic [31:0] redirect_pc, reg_a, reg_b;
  logic [16:0] imm;
  logic [26:0] target;
  logic [31:0] pc, pc_plus1;
  logic        taken, ras_overflow, ras_underflow;
  logic [2:0]  ras_count;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];
  logic [31:0] cur_pc;

  always #5 clock = ~clock;

  pc_sequencer #(
    .PC_W(32), .IMM_W(17), .TGT_W(27), .RAS_DEPTH(4), .RESET_PC(32'h40)
  ) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bne(bne), .blt(blt), .jp(jp), .jal(jal), .jr(jr), .ret(ret), .bex(bex),
    .is_not_equal(is_not_equal), .is_less_than(is_less_than),
    .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .target(target),
    .pc(pc), .pc_plus1(pc_plus1), .taken(taken), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string n, input logic [10:0] f, input logic [31:0] rpc,
                     input logic [31:0] ra, input logic [31:0] rb, input logic [16:0] im,
                     input logic [26:0] tg, input logic [31:0] epc, input logic et,
                     input logic [2:0] ec, input logic eo, input logic eu);
    vec_t v;
    v.name = n; v.flags = f; v.rpc = rpc; v.ra = ra; v.rb = rb; v.imm = im; v.tgt = tg;
    v.exp_pc = epc; v.exp_taken = et; v.exp_cnt = ec; v.exp_ovf = eo; v.exp_unf = eu;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [10:0] f, input logic [31:0] rpc, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [16:0] im, input logic [26:0] tg);
    {stall, redirect_valid, bne, blt, jp, jal, jr, ret, bex, is_not_equal, is_less_than} = f;
    redirect_pc = rpc; reg_a = ra; reg_b = rb; imm = im; target = tg;
  endtask

  initial begin
    // name, flags, redirect_pc, reg_a, reg_b, imm, target, exp pc, taken, count, ovf, unf
    add("idle0", 11'h0, 0, 0, 0, 0, 0, 32'h41, 0, 0, 0, 0);
    add("idle1", 11'h0, 0, 0, 0, 0, 0, 32'h42, 0, 0, 0, 0);
    add("idle2", 11'h0, 0, 0, 0, 0, 0, 32'h43, 0, 0, 0, 0);
    add("redir10", F_REDIR, 32'h10, 0, 0, 0, 0, 32'h10, 1, 0, 0, 0);
    add("bne_back", F_BNE | F_INE, 0, 0, 0, 17'h1FFFE, 0, 32'h0F, 1, 0, 0, 0);
    add("redir10_seq", F_REDIR, 32'h10, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0);
    add("bne_eq", F_BNE, 0, 0, 0, 17'h1FFFE, 0, 32'h11, 0, 0, 0, 0);
    add("blt_fwd", F_BLT | F_ILT, 0, 0, 0, 17'h5, 0, 32'h17, 1, 0, 0, 0);
    add("blt_wrongcmp", F_BLT | F_INE, 0, 0, 0, 17'h5, 0, 32'h18, 0, 0, 0, 0);
    add("redir100", F_REDIR, 32'h100, 0, 0, 0, 0, 32'h100, 1, 0, 0, 0);
    add("jal1", F_JAL, 0, 0, 0, 0, 27'h800, 32'h800, 1, 1, 0, 0);
    add("redir200", F_REDIR, 32'h200, 0, 0, 0, 0, 32'h200, 1, 1, 0, 0);
    add("jal2", F_JAL, 0, 0, 0, 0, 27'h800, 32'h800, 1, 2, 0, 0);
    add("redir300", F_REDIR, 32'h300, 0, 0, 0, 0, 32'h300, 1, 2, 0, 0);
    add("jal3", F_JAL, 0, 0, 0, 0, 27'h800, 32'h800, 1, 3, 0, 0);
    add("redir400", F_REDIR, 32'h400, 0, 0, 0, 0, 32'h400, 1, 3, 0, 0);
    add("jal4", F_JAL, 0, 0, 0, 0, 27'h800, 32'h800, 1, 4, 0, 0);
    add("redir500", F_REDIR, 32'h500, 0, 0, 0, 0, 32'h500, 1, 4, 0, 0);
    add("jal5_ovf", F_JAL, 0, 0, 0, 0, 27'h800, 32'h800, 1, 4, 1, 0);
    add("ret1", F_RET, 0, 0, 32'h77, 0, 0, 32'h501, 1, 3, 0, 0);
    add("ret2", F_RET, 0, 0, 32'h77, 0, 0, 32'h401, 1, 2, 0, 0);
    add("ret3", F_RET, 0, 0, 32'h77, 0, 0, 32'h301, 1, 1, 0, 0);
    add("ret4", F_RET, 0, 0, 32'h77, 0, 0, 32'h201, 1, 0, 0, 0);
    add("ret5_unf", F_RET, 0, 0, 32'h77, 0, 0, 32'h77, 1, 0, 0, 1);
    add("unf_clear", 11'h0, 0, 0, 0, 0, 0, 32'h78, 0, 0, 0, 0);
    add("redir_wins", F_REDIR | F_BEX | F_JR, 32'h999, 1, 32'h456, 0, 27'h123, 32'h999, 1, 0, 0, 0);
    add("bex_wins", F_BEX | F_JR, 0, 1, 32'h456, 0, 27'h123, 32'h123, 1, 0, 0, 0);
    add("bex_nt_jr", F_BEX | F_JR, 0, 0, 32'h456, 0, 27'h123, 32'h456, 1, 0, 0, 0);
    add("jal_ret", F_JAL | F_RET, 0, 0, 32'h77, 0, 27'h800, 32'h800, 1, 1, 0, 0);
    add("ret_pop", F_RET, 0, 0, 32'h77, 0, 0, 32'h457, 1, 0, 0, 0);
    add("stall1", F_STALL | F_JAL, 0, 0, 0, 0, 27'h900, 32'h457, 1, 0, 0, 0);
    add("stall2", F_STALL | F_JAL, 0, 0, 0, 0, 27'h900, 32'h457, 1, 0, 0, 0);
    add("stall3", F_STALL | F_JAL, 0, 0, 0, 0, 27'h900, 32'h457, 1, 0, 0, 0);
    add("unstall_jal", F_JAL, 0, 0, 0, 0, 27'h900, 32'h900, 1, 1, 0, 0);
    add("ret_unstall", F_RET, 0, 0, 32'h77, 0, 0, 32'h458, 1, 0, 0, 0);
    add("stall_redir", F_STALL | F_REDIR, 32'hABC, 0, 0, 0, 0, 32'hABC, 1, 0, 0, 0);
    add("redir_max", F_REDIR, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
    add("wrap", 11'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add("jal_zext", F_JAL, 0, 0, 0, 0, 27'h7FF_FFFF, 32'h07FF_FFFF, 1, 1, 0, 0);
    add("bne_pos", F_BNE | F_INE, 0, 0, 0, 17'h0FFFF, 0, 32'h0800_FFFF, 1, 1, 0, 0);
    add("bexnt_ret", F_BEX | F_RET, 0, 0, 32'h77, 0, 27'h123, 32'h1, 1, 0, 0, 0);
    add("jp_nopush", F_JP, 0, 0, 0, 0, 27'h300, 32'h300, 1, 0, 0, 0);

    reset_n = 1'b0;
    drive(11'h0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", pc, 32'h40);
    check("rst_cnt", 32'(ras_count), 0);
    check("rst_ovf", 32'(ras_overflow), 0);
    check("rst_unf", 32'(ras_underflow), 0);
    @(negedge clock);
    reset_n = 1'b1;
    cur_pc = 32'h40;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clock);
      drive(vecs[i].flags, vecs[i].rpc, vecs[i].ra, vecs[i].rb, vecs[i].imm, vecs[i].tgt);
      #1;
      check({vecs[i].name, ".pc_plus1"}, pc_plus1, cur_pc + 32'd1);
      check({vecs[i].name, ".taken"}, 32'(taken), 32'(vecs[i].exp_taken));
      @(posedge clock);
      #1;
      check({vecs[i].name, ".pc"}, pc, vecs[i].exp_pc);
      check({vecs[i].name, ".cnt"}, 32'(ras_count), 32'(vecs[i].exp_cnt));
      check({vecs[i].name, ".ovf"}, 32'(ras_overflow), 32'(vecs[i].exp_ovf));
      check({vecs[i].name, ".unf"}, 32'(ras_underflow), 32'(vecs[i].exp_unf));
      cur_pc = vecs[i].exp_pc;
    end

    // Asynchronous reset between edges in the middle of a RAS sequence.
    @(negedge clock);
    drive(F_JAL, 0, 0, 0, 0, 27'h800);
    @(posedge clock);
    #1;
    check("mid_jal.pc", pc, 32'h800);
    check("mid_jal.cnt", 32'(ras_count), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.pc", pc, 32'h40);
    check("async_rst.cnt", 32'(ras_count), 0);
    @(negedge clock);
    drive(11'h0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst.pc", pc, 32'h41);
    check("post_rst.cnt", 32'(ras_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
